// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the iterative multiply/divide unit.
//   - op encodings (MULT/MULTU/DIV/DIVU)
//   - FSM state encoding (IDLE, CALC, FIX, DONE)
//   - small decode helpers for op class
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // Signed variants have op[0] clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negation.
// Used both to take operand magnitudes and to restore result signs.
// Ports:
//   value  in  W  input value
//   neg    in  1  negate when set
//   result out W  neg ? -value : value
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit owning HI/LO.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle combinational multiply).
// Ports:
//   clk, rst            clock, async active-high reset
//   start, op           launch op (MULT/MULTU/DIV/DIVU), sampled in IDLE
//   rs_data, rt_data    multiplicand/dividend, multiplier/divisor
//   flush               cancel in-flight operation
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured when not busy
//   busy, done          in-flight flag, one-cycle completion pulse
//   div_zero            sticky divide-by-zero flag
//   hi, lo              HI/LO registers
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned W2 = 2 * WIDTH;

  logic [1:0]       state, state_nxt;
  logic [1:0]       op_q;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic [W2-1:0]    acc;       // {upper, lower}: product, or {remainder, quotient}
  logic [CW-1:0]    cnt;

  logic             accept, fast_mul, in_neg_a, in_neg_b, div_by_zero;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fixed, rem_fixed;
  logic [W2-1:0]    prod_fixed, mul_next, div_next, fix_val;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;

  assign accept   = (state == ST_IDLE) && start && !flush;
  assign in_neg_a = op_is_signed(op) & rs_data[WIDTH-1];
  assign in_neg_b = op_is_signed(op) & rt_data[WIDTH-1];

`ifdef MDU_FAST_MUL_EN
  logic [W2-1:0] fast_prod;
  // Sign-extending to 2*WIDTH makes the truncated product correct for MULT and MULTU.
  assign fast_prod = {{WIDTH{in_neg_a}}, rs_data} * {{WIDTH{in_neg_b}}, rt_data};
  assign fast_mul  = !op_is_div(op);
`else
  assign fast_mul  = 1'b0;
`endif

  // Operand magnitudes at launch
  mdu_sign_fix #(.W(WIDTH)) u_a_mag (.value(rs_data), .neg(in_neg_a), .result(a_mag));
  mdu_sign_fix #(.W(WIDTH)) u_b_mag (.value(rt_data), .neg(in_neg_b), .result(b_mag));

  // Sign restoration in FIX
  mdu_sign_fix #(.W(W2))    u_prod  (.value(acc), .neg(neg_a ^ neg_b), .result(prod_fixed));
  mdu_sign_fix #(.W(WIDTH)) u_quo   (.value(acc[WIDTH-1:0]), .neg(neg_a ^ neg_b), .result(quo_fixed));
  mdu_sign_fix #(.W(WIDTH)) u_rem   (.value(acc[W2-1:WIDTH]), .neg(neg_a), .result(rem_fixed));

  // One radix-2 step for each operation class
  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    // No borrow means the shifted partial remainder covers the divisor.
    div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Divide by zero: the restoring loop already leaves rem=dividend; force quotient to all ones.
  assign div_by_zero = (opnd == '0);
  assign fix_val = op_is_div(op_q) ? {rem_fixed, (div_by_zero ? {WIDTH{1'b1}} : quo_fixed)}
                                   : prod_fixed;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = fast_mul ? ST_DONE : ST_CALC;
      ST_CALC: if (flush) state_nxt = ST_IDLE;
               else if (cnt == CW'(WIDTH - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      // MTHI/MTLO first so a result load in DONE overrides them
      if (!busy && hi_we) hi <= wdata;
      if (!busy && lo_we) lo <= wdata;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= op;
            neg_a    <= in_neg_a;
            neg_b    <= in_neg_b;
            cnt      <= '0;
            div_zero <= 1'b0;
            opnd     <= op_is_div(op) ? b_mag : a_mag;
`ifdef MDU_FAST_MUL_EN
            if (fast_mul) acc <= fast_prod;
            else          acc <= {{WIDTH{1'b0}}, (op_is_div(op) ? a_mag : b_mag)};
`else
            acc      <= {{WIDTH{1'b0}}, (op_is_div(op) ? a_mag : b_mag)};
`endif
            busy     <= !fast_mul;
          end
        end
        ST_CALC: begin
          if (flush) begin
            busy <= 1'b0;
          end else begin
            acc <= op_is_div(op_q) ? div_next : mul_next;
            cnt <= cnt + CW'(1);
          end
        end
        ST_FIX: begin
          busy <= 1'b0;
          if (!flush) acc <= fix_val;
        end
        ST_DONE: begin
          // Result lands even under flush; only the pulse is suppressed.
          hi       <= acc[W2-1:WIDTH];
          lo       <= acc[WIDTH-1:0];
          div_zero <= op_is_div(op_q) && div_by_zero;
          done     <= !flush;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed + randomized self-check of mdu_iter against an arithmetic model.
// Honours MDU_FAST_MUL_EN when the build defines it.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] hi_m, lo_m;
  logic         dz_m;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MDU_MULT:  res = 64'(sa * sb);
      MDU_MULTU: res = {32'h0, a} * {32'h0, b};
      MDU_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
    if (!o[1]) return 1;
`endif
    return W + 2;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Launch one op, optionally with a coincident MTHI and a disturbance (MTLO + start while busy)
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit wr_hi, input bit disturb);
    logic [63:0] r;
    logic [31:0] w;
    int          cyc, bcnt;
    bit          got;
    w = $urandom;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b; hi_we = wr_hi; wdata = w;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check({tag, ":dz_clear"}, div_zero, 1'b0);
    if (wr_hi) check({tag, ":hi_we_now"}, hi, w);
    bcnt = 0; got = 0; cyc = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      if (disturb && i == 4) begin
        lo_we = 1'b1; wdata = 32'hA5A5_A5A5; start = 1'b1; op = MDU_MULTU;
        rs_data = 32'($urandom); rt_data = 32'($urandom);
      end
      if (disturb && i == 5) begin
        lo_we = 1'b0; start = 1'b0;
        check({tag, ":lo_we_busy"}, lo, lo_m);
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
      if (done) begin got = 1; cyc = i; end
    end
    check({tag, ":latency"}, 64'(cyc), 64'(exp_lat(o)));
    check({tag, ":busy_cycles"}, 64'(bcnt), 64'((exp_lat(o) == 1) ? 0 : W + 1));
    check({tag, ":busy_at_done"}, busy, 1'b0);
    r = model(o, a, b);
    hi_m = r[63:32];
    lo_m = r[31:0];
    dz_m = o[1] && (b == 0);
    check({tag, ":hi"}, hi, hi_m);
    check({tag, ":lo"}, lo, lo_m);
    check({tag, ":div_zero"}, div_zero, dz_m);
    @(posedge clk); #1;
    check({tag, ":done_one_cycle"}, done, 1'b0);
    check({tag, ":idle_after"}, busy, 1'b0);
  endtask

  task automatic flush_test(input logic [1:0] o);
    int dn;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = 32'd5; rt_data = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush:busy_drop", busy, 1'b0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("flush:no_done", 64'(dn), 64'(0));
    check("flush:hi_kept", hi, hi_m);
    check("flush:lo_kept", lo, lo_m);
    // flush beats start in the same cycle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MDU_DIVU;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush:beats_start", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = MDU_MULT; rs_data = '0; rt_data = '0; wdata = '0;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:busy", busy, 1'b0);
    check("reset:done", done, 1'b0);
    check("reset:div_zero", div_zero, 1'b0);
    check("reset:hi", hi, 32'h0);
    check("reset:lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 0, 0);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0);
    run_op("divu_zero", MDU_DIVU, 32'h1234_5678, 32'h0, 0, 0);
    run_op("mult_after_dz", MDU_MULT, 32'd7, 32'hFFFF_FFFA, 0, 0);
    run_op("div_zero_signed", MDU_DIV, 32'h8765_4321, 32'h0, 0, 0);
    run_op("mult_minmin", MDU_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div_neg_rem", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0);

`ifdef MDU_FAST_MUL_EN
    flush_test(MDU_DIV);
`else
    flush_test(MDU_MULT);
`endif
    run_op("after_flush", MDU_MULT, 32'd5, 32'hFFFF_FFFD, 0, 0);

    run_op("busy_writes", MDU_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    lo_we = 1'b0;
    lo_m = 32'hA5A5_A5A5;
    check("mtlo_idle", lo, lo_m);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    hi_we = 1'b0;
    hi_m = 32'h5A5A_0F0F;
    check("mthi_idle", hi, hi_m);
    check("mtlo_hold", lo, lo_m);

    for (int k = 0; k < 40; k++) begin
      run_op($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(),
             $urandom_range(0, 3) == 0, 0);
    end

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; rs_data = 32'hFFFF_0000; rt_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid:busy", busy, 1'b0);
    check("rst_mid:hi", hi, 32'h0);
    check("rst_mid:lo", lo, 32'h0);
    check("rst_mid:div_zero", div_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    run_op("after_rst", MDU_DIV, 32'hFFFF_FF00, 32'd16, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
